// File: rtl/rgb2hsv_pkg.sv
// rgb2hsv_pkg: shared constants and the stage tag carried alongside the
// divider pipelines of the RGB-to-HSV converter.
package rgb2hsv_pkg;

  localparam int HUE_SECTOR      = 60;
  localparam int HUE_FULL        = 360;
  localparam int SAT_SCALE       = 255;
  localparam int HUE_BASE_R      = 0;
  localparam int HUE_BASE_G      = 120;
  localparam int HUE_BASE_B      = 240;
  localparam int RGB2HSV_LATENCY = 10;

  // Side information produced by the prepare stage and consumed by assemble
  typedef struct packed {
    logic       valid;
    logic [8:0] base;
    logic       sign;
    logic       zflag_max;
    logic       zflag_delta;
    logic [7:0] v;
  } hsv_tag_t;

endpackage

// File: rtl/rgb2hsv_div.sv
// rgb2hsv_div: pipelined restoring divider, one quotient bit per stage,
// MSB first, floored result. Valid and an opaque tag travel with the data.
// The caller guarantees numer < (denom << Q_W), so Q_W bits never overflow.
// A zero divisor yields an all-ones quotient; the caller masks it.
module rgb2hsv_div #(
  parameter int N_W   = 16,
  parameter int D_W   = 8,
  parameter int Q_W   = 8,
  parameter int TAG_W = 1
) (
  input  logic             clk_Image_Process,
  input  logic             Rst,
  input  logic             in_valid,
  input  logic [N_W-1:0]   numer,
  input  logic [D_W-1:0]   denom,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [Q_W-1:0]   quot,
  output logic [TAG_W-1:0] out_tag
);

  // Remainder must hold both the numerator and the divisor shifted by Q_W-1
  localparam int W = (N_W > D_W + Q_W) ? N_W : D_W + Q_W;

  logic [Q_W-1:0]   vld_q;
  logic [W-1:0]     rem_q [Q_W-1];
  logic [D_W-1:0]   den_q [Q_W-1];
  logic [Q_W-1:0]   quo_q [Q_W];
  logic [TAG_W-1:0] tag_q [Q_W];

  logic [Q_W:0]     src_vld;
  logic [W-1:0]     src_rem [Q_W];
  logic [D_W-1:0]   src_den [Q_W];
  logic [Q_W-1:0]   src_quo [Q_W+1];
  logic [TAG_W-1:0] src_tag [Q_W+1];

  logic [W-1:0]     dsh     [Q_W];
  logic [Q_W-1:0]   ge;
  logic [W-1:0]     rem_nxt [Q_W-1];

  // Stage inputs: index 0 is the module input, index i+1 is register i
  always_comb begin
    src_vld[0] = in_valid;
    src_rem[0] = W'(numer);
    src_den[0] = denom;
    src_quo[0] = '0;
    src_tag[0] = in_tag;
    for (int i = 0; i < Q_W; i++) begin
      src_vld[i+1] = vld_q[i];
      src_quo[i+1] = quo_q[i];
      src_tag[i+1] = tag_q[i];
    end
    for (int i = 0; i < Q_W - 1; i++) begin
      src_rem[i+1] = rem_q[i];
      src_den[i+1] = den_q[i];
    end
  end

  // Trial subtraction of the divisor aligned to this stage's quotient bit
  always_comb begin
    ge = '0;
    for (int i = 0; i < Q_W; i++) begin
      dsh[i] = W'(src_den[i]) << (Q_W - 1 - i);
      ge[i]  = (src_rem[i] >= dsh[i]);
    end
    for (int i = 0; i < Q_W - 1; i++) begin
      rem_nxt[i] = ge[i] ? (src_rem[i] - dsh[i]) : src_rem[i];
    end
  end

  // Pipeline registers; the last stage needs no remainder or divisor
  always_ff @(posedge clk_Image_Process or negedge Rst) begin
    if (!Rst) begin
      vld_q <= '0;
      for (int i = 0; i < Q_W; i++) begin
        quo_q[i] <= '0;
        tag_q[i] <= '0;
      end
      for (int i = 0; i < Q_W - 1; i++) begin
        rem_q[i] <= '0;
        den_q[i] <= '0;
      end
    end else begin
      vld_q <= src_vld[Q_W-1:0];
      for (int i = 0; i < Q_W; i++) begin
        quo_q[i] <= {src_quo[i][Q_W-2:0], ge[i]};
        tag_q[i] <= src_tag[i];
      end
      for (int i = 0; i < Q_W - 1; i++) begin
        rem_q[i] <= rem_nxt[i];
        den_q[i] <= src_den[i];
      end
    end
  end

  assign out_valid = src_vld[Q_W];
  assign quot      = src_quo[Q_W];
  assign out_tag   = src_tag[Q_W];

endmodule

// File: rtl/rgb2hsv.sv
// rgb2hsv: streaming 8-bit RGB to HSV (H 0..359, S/V 0..255) converter.
// One pixel per clock, fixed latency of 10 clocks, no back-pressure.
// Optional macro RGB2HSV_SYNC_EN adds Hsync/Vsync/De pass-through delayed
// by the same latency.
module rgb2hsv
  import rgb2hsv_pkg::*;
#(
  parameter int DIV_STAGES        = 8,
  parameter int RGB2HSV_Delay_Clk = RGB2HSV_LATENCY
) (
  input  logic       clk_Image_Process,
  input  logic       Rst,
  input  logic       RGB_Data_Valid,
  input  logic [7:0] RGB_Data_R,
  input  logic [7:0] RGB_Data_G,
  input  logic [7:0] RGB_Data_B,
  output logic       HSV_Data_Valid,
  output logic [8:0] HSV_Data_H,
  output logic [7:0] HSV_Data_S,
  output logic [7:0] HSV_Data_V,
  output logic [3:0] Delay_Num
`ifdef RGB2HSV_SYNC_EN
  ,
  input  logic       RGB_Hsync,
  input  logic       RGB_Vsync,
  input  logic       RGB_De,
  output logic       HSV_Hsync,
  output logic       HSV_Vsync,
  output logic       HSV_De
`endif
);

  logic [7:0] mx_c, mn_c, delta_c, hi_c, lo_c, absd_c;
  logic [8:0] base_c;
  logic       sub_c, sel_r_c;

  hsv_tag_t   tag_s0;
  logic [15:0] num_s_s0;
  logic [7:0]  den_s_s0;
  logic [13:0] num_h_s0;
  logic [7:0]  den_h_s0;

  logic                  s_valid, h_valid;
  logic [DIV_STAGES-1:0] q_s, q_h;
  logic [8:0]            s_tag;
  logic [10:0]           h_tag;
  logic                  s_zmax, h_sign, h_zdelta;
  logic [7:0]            s_v;
  logic [8:0]            h_base;
  logic [9:0]            h_c;

  // Max-channel selection (R, then G, then B on ties) and hue sector setup
  always_comb begin
    mx_c    = RGB_Data_R;
    hi_c    = RGB_Data_G;
    lo_c    = RGB_Data_B;
    base_c  = 9'(HUE_BASE_R);
    sel_r_c = 1'b0;
    if (RGB_Data_R >= RGB_Data_G && RGB_Data_R >= RGB_Data_B) begin
      sel_r_c = 1'b1;
    end else if (RGB_Data_G >= RGB_Data_B) begin
      mx_c   = RGB_Data_G;
      hi_c   = RGB_Data_B;
      lo_c   = RGB_Data_R;
      base_c = 9'(HUE_BASE_G);
    end else begin
      mx_c   = RGB_Data_B;
      hi_c   = RGB_Data_R;
      lo_c   = RGB_Data_G;
      base_c = 9'(HUE_BASE_B);
    end
    mn_c = (RGB_Data_R < RGB_Data_G) ? RGB_Data_R : RGB_Data_G;
    if (RGB_Data_B < mn_c) mn_c = RGB_Data_B;
    delta_c = mx_c - mn_c;
    sub_c   = (hi_c < lo_c);
    absd_c  = sub_c ? (lo_c - hi_c) : (hi_c - lo_c);
    if (sel_r_c && sub_c) base_c = 9'(HUE_FULL);
  end

  // Prepare stage: register the divider operands and the side tag
  always_ff @(posedge clk_Image_Process or negedge Rst) begin
    if (!Rst) begin
      tag_s0   <= '0;
      num_s_s0 <= '0;
      den_s_s0 <= '0;
      num_h_s0 <= '0;
      den_h_s0 <= '0;
    end else begin
      tag_s0.valid       <= RGB_Data_Valid;
      tag_s0.base        <= base_c;
      tag_s0.sign        <= sub_c;
      tag_s0.zflag_max   <= (mx_c == 8'd0);
      tag_s0.zflag_delta <= (delta_c == 8'd0);
      tag_s0.v           <= mx_c;
      num_s_s0           <= 16'(delta_c) * 16'(SAT_SCALE);
      den_s_s0           <= mx_c;
      num_h_s0           <= 14'(absd_c) * 14'(HUE_SECTOR);
      den_h_s0           <= delta_c;
    end
  end

  // The tag is split so each divider carries only the fields its result needs
  rgb2hsv_div #(.N_W(16), .D_W(8), .Q_W(DIV_STAGES), .TAG_W(9)) u_div_s (
    .clk_Image_Process (clk_Image_Process),
    .Rst               (Rst),
    .in_valid          (tag_s0.valid),
    .numer             (num_s_s0),
    .denom             (den_s_s0),
    .in_tag            ({tag_s0.zflag_max, tag_s0.v}),
    .out_valid         (s_valid),
    .quot              (q_s),
    .out_tag           (s_tag)
  );

  rgb2hsv_div #(.N_W(14), .D_W(8), .Q_W(DIV_STAGES), .TAG_W(11)) u_div_h (
    .clk_Image_Process (clk_Image_Process),
    .Rst               (Rst),
    .in_valid          (tag_s0.valid),
    .numer             (num_h_s0),
    .denom             (den_h_s0),
    .in_tag            ({tag_s0.base, tag_s0.sign, tag_s0.zflag_delta}),
    .out_valid         (h_valid),
    .quot              (q_h),
    .out_tag           (h_tag)
  );

  assign {s_zmax, s_v}             = s_tag;
  assign {h_base, h_sign, h_zdelta} = h_tag;

  // Hue offset from the sector base, with the 360 wrap and achromatic mask
  always_comb begin
    if (h_sign) h_c = 10'(h_base) - 10'(q_h);
    else        h_c = 10'(h_base) + 10'(q_h);
    if (h_zdelta || h_c == 10'(HUE_FULL)) h_c = '0;
  end

  // Assemble stage: outputs are forced to zero when no pixel is present
  always_ff @(posedge clk_Image_Process or negedge Rst) begin
    if (!Rst) begin
      HSV_Data_Valid <= 1'b0;
      HSV_Data_H     <= '0;
      HSV_Data_S     <= '0;
      HSV_Data_V     <= '0;
    end else begin
      HSV_Data_Valid <= s_valid & h_valid;
      if (s_valid & h_valid) begin
        HSV_Data_H <= h_c[8:0];
        HSV_Data_S <= s_zmax ? 8'd0 : 8'(q_s);
        HSV_Data_V <= s_v;
      end else begin
        HSV_Data_H <= '0;
        HSV_Data_S <= '0;
        HSV_Data_V <= '0;
      end
    end
  end

  assign Delay_Num = 4'(RGB2HSV_Delay_Clk);

`ifdef RGB2HSV_SYNC_EN
  logic [RGB2HSV_Delay_Clk-1:0] hs_sr, vs_sr, de_sr;

  // Sync signals follow the pixel latency regardless of RGB_Data_Valid
  always_ff @(posedge clk_Image_Process or negedge Rst) begin
    if (!Rst) begin
      hs_sr <= '0;
      vs_sr <= '0;
      de_sr <= '0;
    end else begin
      hs_sr <= {hs_sr[RGB2HSV_Delay_Clk-2:0], RGB_Hsync};
      vs_sr <= {vs_sr[RGB2HSV_Delay_Clk-2:0], RGB_Vsync};
      de_sr <= {de_sr[RGB2HSV_Delay_Clk-2:0], RGB_De};
    end
  end

  assign HSV_Hsync = hs_sr[RGB2HSV_Delay_Clk-1];
  assign HSV_Vsync = vs_sr[RGB2HSV_Delay_Clk-1];
  assign HSV_De    = de_sr[RGB2HSV_Delay_Clk-1];
`endif

endmodule

// File: tb/tb_rgb2hsv.sv
// tb_rgb2hsv: scoreboard bench for rgb2hsv. The driver pushes the expected
// HSV triple and issue cycle for each valid pixel; a negedge monitor pops and
// compares whenever HSV_Data_Valid is high and checks zeros otherwise.
// Honours RGB2HSV_SYNC_EN for the optional sync pass-through.
module tb_rgb2hsv;

  logic       clk_Image_Process = 1'b0;
  logic       Rst;
  logic       RGB_Data_Valid;
  logic [7:0] RGB_Data_R, RGB_Data_G, RGB_Data_B;
  logic       HSV_Data_Valid;
  logic [8:0] HSV_Data_H;
  logic [7:0] HSV_Data_S, HSV_Data_V;
  logic [3:0] Delay_Num;
`ifdef RGB2HSV_SYNC_EN
  logic       RGB_Hsync = 1'b0, RGB_Vsync = 1'b0, RGB_De = 1'b0;
  logic       HSV_Hsync, HSV_Vsync, HSV_De;
  logic [2:0] sync_hist [0:2047];
  int         rel_cyc = 1 << 30;
`endif

  typedef struct {
    int h;
    int s;
    int v;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cycle    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  rgb2hsv dut (
    .clk_Image_Process (clk_Image_Process),
    .Rst               (Rst),
    .RGB_Data_Valid    (RGB_Data_Valid),
    .RGB_Data_R        (RGB_Data_R),
    .RGB_Data_G        (RGB_Data_G),
    .RGB_Data_B        (RGB_Data_B),
    .HSV_Data_Valid    (HSV_Data_Valid),
    .HSV_Data_H        (HSV_Data_H),
    .HSV_Data_S        (HSV_Data_S),
    .HSV_Data_V        (HSV_Data_V),
    .Delay_Num         (Delay_Num)
`ifdef RGB2HSV_SYNC_EN
    ,
    .RGB_Hsync         (RGB_Hsync),
    .RGB_Vsync         (RGB_Vsync),
    .RGB_De            (RGB_De),
    .HSV_Hsync         (HSV_Hsync),
    .HSV_Vsync         (HSV_Vsync),
    .HSV_De            (HSV_De)
`endif
  );

  always #5 clk_Image_Process = ~clk_Image_Process;

  // Free-running cycle count used to measure latency
  always @(posedge clk_Image_Process) cycle <= cycle + 1;

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference conversion straight from the HSV definition with integer floors
  function automatic exp_t model(input int r, input int g, input int b, input int cyc);
    exp_t e;
    int mx, mn, delta, diff, base, q, h;
    if (r >= g && r >= b) begin
      mx = r; base = 0; diff = g - b;
    end else if (g >= b) begin
      mx = g; base = 120; diff = b - r;
    end else begin
      mx = b; base = 240; diff = r - g;
    end
    mn    = (r < g) ? r : g;
    mn    = (b < mn) ? b : mn;
    delta = mx - mn;
    if (delta == 0) h = 0;
    else begin
      q = (60 * ((diff < 0) ? -diff : diff)) / delta;
      h = (diff < 0) ? base - q : base + q;
      h = (h + 360) % 360;
    end
    e.h   = h;
    e.s   = (mx == 0) ? 0 : (delta * 255) / mx;
    e.v   = mx;
    e.cyc = cyc;
    return e;
  endfunction

  task automatic apply_stimulus(input logic vld, input int r, input int g, input int b);
    @(posedge clk_Image_Process);
    #1;
    RGB_Data_Valid = vld;
    RGB_Data_R     = 8'(r);
    RGB_Data_G     = 8'(g);
    RGB_Data_B     = 8'(b);
    if (vld) sb.push_back(model(r, g, b, cycle));
  endtask

  task automatic pulse_reset();
    @(posedge clk_Image_Process);
    #3;
    Rst            = 1'b0;
    RGB_Data_Valid = 1'b0;
    sb.delete();
    #1;
    check_output("rst_async_valid", int'(HSV_Data_Valid), 0);
    check_output("rst_async_h", int'(HSV_Data_H), 0);
    check_output("rst_async_s", int'(HSV_Data_S), 0);
    check_output("rst_async_v", int'(HSV_Data_V), 0);
    repeat (2) @(posedge clk_Image_Process);
    #3;
    Rst = 1'b1;
`ifdef RGB2HSV_SYNC_EN
    rel_cyc = cycle;
`endif
  endtask

  // Monitor: pop and compare on every valid output, expect zeros otherwise
  always @(negedge clk_Image_Process) begin
    exp_t e;
    if (Rst === 1'b1) begin
      if (HSV_Data_Valid) begin
        if (sb.size() == 0) check_output("unexpected_valid", 1, 0);
        else begin
          e = sb.pop_front();
          check_output("hue", int'(HSV_Data_H), e.h);
          check_output("sat", int'(HSV_Data_S), e.s);
          check_output("val", int'(HSV_Data_V), e.v);
          check_output("latency", cycle - e.cyc, 10);
        end
      end else begin
        check_output("idle_h", int'(HSV_Data_H), 0);
        check_output("idle_s", int'(HSV_Data_S), 0);
        check_output("idle_v", int'(HSV_Data_V), 0);
      end
`ifdef RGB2HSV_SYNC_EN
      if (cycle - 10 >= rel_cyc)
        check_output("sync_delay", int'({HSV_Hsync, HSV_Vsync, HSV_De}),
                     int'(sync_hist[(cycle - 10) % 2048]));
`endif
    end
  end

`ifdef RGB2HSV_SYNC_EN
  // Arbitrary sync patterns, recorded per cycle for the delayed comparison
  always @(posedge clk_Image_Process) begin
    #1;
    {RGB_Hsync, RGB_Vsync, RGB_De} = 3'($urandom);
    sync_hist[cycle % 2048] = {RGB_Hsync, RGB_Vsync, RGB_De};
  end
`endif

  int dir_px [9][3] = '{
    '{255, 0, 0}, '{0, 255, 0}, '{0, 0, 255},
    '{255, 255, 0}, '{128, 128, 128}, '{0, 0, 0},
    '{200, 100, 50}, '{255, 0, 128}, '{255, 0, 1}
  };
  int pat [6] = '{1, 0, 0, 1, 1, 0};

  initial begin
    Rst            = 1'b0;
    RGB_Data_Valid = 1'b0;
    RGB_Data_R     = '0;
    RGB_Data_G     = '0;
    RGB_Data_B     = '0;
    repeat (3) @(posedge clk_Image_Process);
    #2;
    check_output("reset_valid", int'(HSV_Data_Valid), 0);
    check_output("reset_h", int'(HSV_Data_H), 0);
    check_output("reset_s", int'(HSV_Data_S), 0);
    check_output("reset_v", int'(HSV_Data_V), 0);
    check_output("delay_num", int'(Delay_Num), 10);
    @(posedge clk_Image_Process);
    #3;
    Rst = 1'b1;
`ifdef RGB2HSV_SYNC_EN
    rel_cyc = cycle;
`endif

    for (int i = 0; i < 9; i++) apply_stimulus(1'b1, dir_px[i][0], dir_px[i][1], dir_px[i][2]);

    for (int i = 0; i < 64; i++)
      apply_stimulus(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));

    for (int i = 0; i < 6; i++)
      apply_stimulus(pat[i] != 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));

    for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 0, 0, 0);
    check_output("drain_stream", sb.size(), 0);

    for (int i = 0; i < 20; i++) begin
      if (i == 12) pulse_reset();
      apply_stimulus(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    for (int i = 0; i < 14; i++) apply_stimulus(1'b0, 0, 0, 0);
    check_output("drain_reset", sb.size(), 0);
    check_output("delay_num_end", int'(Delay_Num), 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends even if the flow above stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
